// File: rtl/ringbuf_mc_if.sv
// Bus bundle for the multi-channel ring buffer: producer/consumer requests
// go in, read data and per-channel status come back out.
interface ringbuf_mc_if #(
  parameter int data_width   = 8,
  parameter int addr_size    = 4,
  parameter int channel_bits = 1
);
  logic                       wr_en;
  logic [channel_bits-1:0]    wr_chan;
  logic [data_width-1:0]      txda;
  logic                       rd_en;
  logic [channel_bits-1:0]    rd_chan;
  logic                       clr_flags;
  logic [data_width-1:0]      rxda;
  logic                       outstrobe;
  logic [2**channel_bits-1:0] full;
  logic [2**channel_bits-1:0] empty;
  logic [2**channel_bits-1:0] overflow;
  logic [2**channel_bits-1:0] underflow;
  logic [addr_size:0]         rd_level;

  modport master (
    output wr_en, wr_chan, txda, rd_en, rd_chan, clr_flags,
    input  rxda, outstrobe, full, empty, overflow, underflow, rd_level
  );

  modport slave (
    input  wr_en, wr_chan, txda, rd_en, rd_chan, clr_flags,
    output rxda, outstrobe, full, empty, overflow, underflow, rd_level
  );
endinterface

// File: rtl/ringbuf_mc.sv
// Multi-channel ring buffer: 2**channel_bits independent FIFO rings of
// 2**addr_size words sharing one storage array addressed as {chan, ptr}.
// One write and one read per cycle, sticky overflow/underflow per channel,
// and an optional overwrite-oldest mode for writes into a full channel.
module ringbuf_mc #(
  parameter int data_width   = 8,
  parameter int addr_size    = 4,
  parameter int channel_bits = 1,
  parameter bit overwrite    = 1'b0
) (
  input logic         clock,
  input logic         reset,
  ringbuf_mc_if.slave bus
);
  localparam int chans = 2 ** channel_bits;
  localparam int words = 2 ** (channel_bits + addr_size);
  localparam logic [addr_size:0] full_cnt = {1'b1, {addr_size{1'b0}}};

  logic [addr_size-1:0]  wr_ptr [chans];
  logic [addr_size-1:0]  rd_ptr [chans];
  logic [addr_size:0]    count  [chans];
  logic [data_width-1:0] mem    [words];

  logic wr_full, rd_empty, same_chan, do_rd, do_wr, ow_bump, ov_event, un_event;
  logic [channel_bits+addr_size-1:0] wr_addr, rd_addr;
  logic [chans-1:0] wr_adv, rd_adv, cnt_inc, cnt_dec;
  logic [chans-1:0] ovf_next, unf_next;

  // Decode requests against current occupancy; a same-channel read frees the slot a full write needs
  always_comb begin
    wr_full   = (count[bus.wr_chan] == full_cnt);
    rd_empty  = (count[bus.rd_chan] == '0);
    same_chan = (bus.wr_chan == bus.rd_chan);
    do_rd     = bus.rd_en && !rd_empty;
    ov_event  = bus.wr_en && wr_full && !(do_rd && same_chan);
    ow_bump   = ov_event && overwrite;
    do_wr     = bus.wr_en && (!ov_event || overwrite);
    un_event  = bus.rd_en && rd_empty;
    wr_addr   = {bus.wr_chan, wr_ptr[bus.wr_chan]};
    rd_addr   = {bus.rd_chan, rd_ptr[bus.rd_chan]};
    wr_adv    = '0;
    rd_adv    = '0;
    cnt_inc   = '0;
    cnt_dec   = '0;
    for (int c = 0; c < chans; c++) begin
      wr_adv[c]  = do_wr && (bus.wr_chan == channel_bits'(c));
      cnt_dec[c] = do_rd && (bus.rd_chan == channel_bits'(c));
      cnt_inc[c] = wr_adv[c] && !ow_bump;
      rd_adv[c]  = cnt_dec[c] || (ow_bump && wr_adv[c]);
    end
    ovf_next = bus.clr_flags ? '0 : bus.overflow;
    unf_next = bus.clr_flags ? '0 : bus.underflow;
    if (ov_event) ovf_next[bus.wr_chan] = 1'b1;
    if (un_event) unf_next[bus.rd_chan] = 1'b1;
  end

  // Per-channel status and the occupancy of whichever channel is being read
  always_comb begin
    bus.full  = '0;
    bus.empty = '0;
    for (int c = 0; c < chans; c++) begin
      bus.full[c]  = (count[c] == full_cnt);
      bus.empty[c] = (count[c] == '0);
    end
    bus.rd_level = count[bus.rd_chan];
  end

  // Pointer, count, flag and read-data registers; reset empties every channel logically
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int c = 0; c < chans; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        count[c]  <= '0;
      end
      bus.overflow  <= '0;
      bus.underflow <= '0;
      bus.rxda      <= '0;
      bus.outstrobe <= 1'b0;
    end else begin
      for (int c = 0; c < chans; c++) begin
        if (wr_adv[c]) wr_ptr[c] <= wr_ptr[c] + addr_size'(1);
        if (rd_adv[c]) rd_ptr[c] <= rd_ptr[c] + addr_size'(1);
        if (cnt_inc[c] && !cnt_dec[c]) count[c] <= count[c] + (addr_size+1)'(1);
        else if (cnt_dec[c] && !cnt_inc[c]) count[c] <= count[c] - (addr_size+1)'(1);
      end
      bus.overflow  <= ovf_next;
      bus.underflow <= unf_next;
      bus.outstrobe <= do_rd;
      if (do_rd) bus.rxda <= mem[rd_addr];
    end
  end

  // Shared storage is never cleared; a read of the slot being overwritten returns the old word
  always_ff @(posedge clock) begin
    if (reset && do_wr) mem[wr_addr] <= bus.txda;
  end
endmodule

// File: doc/ringbuf_mc.md
# ringbuf_mc

Parametrised multi-channel ring buffer, the word-wide, multi-channel successor to the single-stream serial ring buffer. Holds 2**channel_bits independent FIFO rings of 2**addr_size words each in one shared storage array, with one write and one read port per cycle. Adds per-channel full/empty status, sticky overflow/underflow flags and a selectable overwrite-oldest mode. Sits between a packet producer and a retrieval/transmit stage that drains channels by strobe.

## Interface
- data_width, 8, bits per stored word
- addr_size, 4, log2 of per-channel depth (depth = 2**addr_size, addr_size >= 2)
- channel_bits, 1, log2 of channel count (channels = 2**channel_bits, channel_bits >= 1)
- overwrite, 0, 1 = write to a full channel replaces its oldest word; 0 = write dropped

- clock  input  1  sole clock, all state on rising edge
- reset  input  1  synchronous, active-low; sampled on clock rising edge
- wr_en  input  1  write request this cycle
- wr_chan  input  channel_bits  target channel of write
- txda  input  data_width  write data
- rd_en  input  1  read request this cycle
- rd_chan  input  channel_bits  source channel of read
- clr_flags  input  1  clears all sticky overflow/underflow bits
- rxda  output  data_width  registered read data
- outstrobe  output  1  one-cycle pulse: rxda holds newly read word
- full  output  2**channel_bits  per-channel count == depth
- empty  output  2**channel_bits  per-channel count == 0
- overflow  output  2**channel_bits  sticky: write hit full channel
- underflow  output  2**channel_bits  sticky: read hit empty channel
- rd_level  output  addr_size+1  combinational occupancy of channel rd_chan

## Operation
- Per channel: wr_ptr, rd_ptr (addr_size bits, wrap modulo depth), count (addr_size+1 bits, 0..depth).
- Storage address = {chan, ptr}; array of 2**(channel_bits+addr_size) words.
- Write, channel not full: store txda at wr_ptr, wr_ptr+1, count+1.
- Write, channel full, no same-channel read, overwrite=0: word dropped, pointers/count unchanged, overflow[chan] set.
- Write, channel full, no same-channel read, overwrite=1: store at wr_ptr, wr_ptr+1 and rd_ptr+1, count stays depth, overflow[chan] set.
- Read, channel not empty: rxda <= word at rd_ptr, rd_ptr+1, count-1, outstrobe=1 next cycle.
- Read, channel empty: no pointer change, rxda holds, outstrobe=0, underflow[chan] set.
- Simultaneous read and write, same channel:
  - count 0: write performed, read is underflow (no bypass; data not forwarded).
  - count depth: both performed normally, count unchanged, no overflow in either mode.
  - otherwise: both performed, count unchanged.
- Different channels: fully independent.
- clr_flags clears all sticky bits; a set event in the same cycle wins for that bit.
- Reset mid-operation: all channels logically emptied; array contents not cleared but unreachable.

## Timing
- Reset values: rxda 0, outstrobe 0, full all 0, empty all 1, overflow 0, underflow 0, all pointers/counts 0; rd_level 0.
- Read latency 1: rd_en at edge N -> rxda valid and outstrobe high after edge N, for one cycle; rxda holds until next successful read.
- Write at edge N visible to read request presented at edge N+1.
- full/empty/overflow/underflow registered, updated after the edge of the causing event.
- rd_level reflects state after last edge, combinational on rd_chan.
- Back-to-back reads every cycle sustained; throughput one write + one read per cycle.
- reset low overrides all requests in that cycle.

## Test plan
- Reset, then write 0x11,0x22,0x33 to ch0; read ch0 three times -> rxda 0x11,0x22,0x33 on consecutive cycles, outstrobe high 3 cycles, empty[0]=1 afterwards.
- overwrite=0, depth 16: write 0x00..0x10 (17 words) to ch1 -> full[1]=1, overflow[1]=1 after 17th, 16 reads return 0x00..0x0F, 0x10 lost; clr_flags -> overflow[1]=0.
- overwrite=1, same stimulus -> reads return 0x01..0x10, overflow[1]=1, rd_level stays 16 while full.
- Read empty ch0 -> outstrobe 0, rxda unchanged, underflow[0]=1; simultaneous write 0xAA/read on empty ch0 -> underflow set, next read returns 0xAA.
- Interleave ch0/ch1 writes (0xA0.., 0xB0..), read ch1 then ch0 -> per-channel order preserved; full-channel simultaneous read+write -> no overflow, count 16; assert reset mid-stream -> all empty, outstrobe 0 next cycle.
